// File: rtl/auth_pkg.sv
// Shared types and default command codes for the rider-authorisation controller.
package auth_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CONNECTED    = 2'd1,
    DISCONNECTED = 2'd2
  } auth_state_t;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_BUSY = 1'b1
  } rx_state_t;

  localparam logic [7:0] CODE_GO   = 8'h47;
  localparam logic [7:0] CODE_STOP = 8'h53;

endpackage

// File: rtl/auth_session_ctrl_if.sv
// Rider-link bundle: serial line and rider sensor in, power/status out.
interface auth_session_ctrl_if;
  logic       RX;
  logic       rider_off;
  logic       pwr_up;
  logic [1:0] state;
  logic       hb_timeout;
  logic       grace_exp;

  modport master (output RX, rider_off, input pwr_up, state, hb_timeout, grace_exp);
  modport slave  (input RX, rider_off, output pwr_up, state, hb_timeout, grace_exp);
endinterface

// File: rtl/UART_rx.sv
// 8N1 UART receiver; rdy pulses with rx_data valid after a good stop bit.
module UART_rx
  import auth_pkg::*;
#(
  parameter int unsigned BAUD_CYC = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
);

  localparam int unsigned BW   = $clog2(BAUD_CYC + 1);
  localparam int unsigned HALF = BAUD_CYC / 2;

  rx_state_t     st_q, st_d;
  logic          rx_ff1_q, rx_s_q;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shft_q, shft_d;
  logic          rdy_q, rdy_d;

  // Line idles high, so the synchroniser presets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1_q <= 1'b1;
      rx_s_q   <= 1'b1;
    end else begin
      rx_ff1_q <= RX;
      rx_s_q   <= rx_ff1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= RX_IDLE;
      baud_q <= '0;
      bit_q  <= '0;
      shft_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      baud_q <= baud_d;
      bit_q  <= bit_d;
      shft_q <= shft_d;
      rdy_q  <= rdy_d;
    end
  end

  // First sample lands mid start bit, then one sample per bit through the stop bit.
  always_comb begin
    st_d   = st_q;
    baud_d = baud_q;
    bit_d  = bit_q;
    shft_d = shft_q;
    rdy_d  = rdy_q;
    if (clr_rdy) rdy_d = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          st_d   = RX_BUSY;
          baud_d = BW'(HALF);
          bit_d  = '0;
          rdy_d  = 1'b0;
        end
      end
      RX_BUSY: begin
        if (baud_q == '0) begin
          shft_d = {rx_s_q, shft_q[8:1]};
          bit_d  = bit_q + 4'd1;
          baud_d = BW'(BAUD_CYC - 1);
          if (bit_q == 4'd9) begin
            st_d  = RX_IDLE;
            rdy_d = rx_s_q;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
    endcase
  end

  assign rx_data = shft_q[7:0];
  assign rdy     = rdy_q;

endmodule

// File: rtl/auth_session_ctrl.sv
// Rider-authorisation controller: BLE command bytes gate pwr_up, with a
// heartbeat watchdog and a grace-period warning while disconnected.
module auth_session_ctrl
  import auth_pkg::*;
#(
  parameter logic [7:0]  GO_CODE   = CODE_GO,
  parameter logic [7:0]  STOP_CODE = CODE_STOP,
  parameter int unsigned HB_CYC    = 50_000_000,
  parameter int unsigned GRACE_CYC = 150_000_000,
  parameter int unsigned CNT_W     = 28,
  parameter int unsigned BAUD_CYC  = 2604
) (
  input logic                clk,
  input logic                rst_n,
  auth_session_ctrl_if.slave bus
);

  localparam bit              HB_EN     = (HB_CYC != 0);
  localparam bit              GRACE_EN  = (GRACE_CYC != 0);
  localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'((HB_CYC == 0) ? 0 : HB_CYC - 1);
  localparam logic [CNT_W-1:0] GRACE_MAX = CNT_W'(GRACE_CYC);
  localparam logic [CNT_W-1:0] TMR_MAX   = '1;

  auth_state_t      state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       rx_data;
  logic             rdy, clr_rdy, go, stop, hb_fire;

  UART_rx #(.BAUD_CYC(BAUD_CYC)) iRX (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (bus.RX),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy    (rdy)
  );

  // Every received byte is consumed immediately, whatever the state.
  assign clr_rdy = rdy;
  assign go      = rdy && (rx_data == GO_CODE);
  assign stop    = rdy && (rx_data == STOP_CODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // One timer serves both the heartbeat (CONNECTED) and grace (DISCONNECTED) windows.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hb_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (go) state_d = CONNECTED;
      end
      CONNECTED: begin
        if (stop) begin
          timer_d = '0;
          state_d = bus.rider_off ? IDLE : DISCONNECTED;
        end else if (rdy) begin
          timer_d = '0;
        end else if (HB_EN && (timer_q == HB_LAST)) begin
          hb_fire = 1'b1;
          timer_d = '0;
          state_d = DISCONNECTED;
        end else if (timer_q != TMR_MAX) begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      DISCONNECTED: begin
        if (bus.rider_off) begin
          timer_d = '0;
          state_d = IDLE;
        end else if (go) begin
          timer_d = '0;
          state_d = CONNECTED;
        end else if (timer_q != GRACE_MAX) begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.pwr_up     = (state_q == CONNECTED) || (state_q == DISCONNECTED);
  assign bus.state      = state_q;
  assign bus.hb_timeout = hb_fire;
  assign bus.grace_exp  = GRACE_EN && (state_q == DISCONNECTED) && (timer_q == GRACE_MAX);

endmodule
